// File: rtl/id_pkg.sv
// Shared constants and state encoding for the identifier generator and recognizer.
package id_pkg;

    localparam logic [7:0] CH_A_UP = 8'd65;
    localparam logic [7:0] CH_A_LO = 8'd97;
    localparam logic [7:0] CH_0    = 8'd48;
    localparam logic [7:0] CH_SP   = 8'd32;

    localparam int unsigned LETTER_CNT = 26;
    localparam int unsigned DIGIT_CNT  = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LET  = 2'd1;
    localparam logic [1:0] ST_DIG  = 2'd2;
    localparam logic [1:0] ST_SEP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StLet  = ST_LET,
        StDig  = ST_DIG,
        StSep  = ST_SEP
    } state_e;

endpackage

// File: rtl/id_wrap_cnt.sv
// Modulo-K index counter; load has priority over count enable.
module id_wrap_cnt #(
    parameter int unsigned K = 10,
    parameter int unsigned W = $clog2(K)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LAST = W'(K - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/id_gen.sv
// Identifier token transmitter: N letters, M digits, then a separator byte,
// one byte per valid/ready transfer.
module id_gen
    import id_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 15,
    parameter logic [7:0]  SEP_CHAR = CH_SP,
    localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] let_len,
    input  logic [LW-1:0] dig_len,
    input  logic [4:0]    let_seed,
    input  logic          upper,
    output logic [7:0]    char,
    output logic          valid,
    input  logic          ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state;
    logic [LW-1:0] let_cnt;
    logic [LW-1:0] dig_cnt;
    logic          upper_q;
    logic [4:0]    li;
    logic [3:0]    di;
    logic          xfer;
    logic          accept;
    logic [4:0]    seed_ok;

    assign xfer    = valid & ready;
    assign accept  = (state == StIdle) && start && (let_len != '0) && (dig_len != '0);
    assign seed_ok = (let_seed > 5'd25) ? 5'd0 : let_seed;

    id_wrap_cnt #(
        .K (LETTER_CNT),
        .W (5)
    ) u_let_idx (
        .clk      (clk),
        .reset    (reset),
        .en       ((state == StLet) && xfer),
        .load     (accept),
        .load_val (seed_ok),
        .count    (li)
    );

    id_wrap_cnt #(
        .K (DIGIT_CNT),
        .W (4)
    ) u_dig_idx (
        .clk      (clk),
        .reset    (reset),
        .en       ((state == StDig) && xfer),
        .load     (accept),
        .load_val (4'd0),
        .count    (di)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            let_cnt <= '0;
            dig_cnt <= '0;
            upper_q <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        let_cnt <= let_len;
                        dig_cnt <= dig_len;
                        upper_q <= upper;
                        state   <= StLet;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                StLet: begin
                    if (xfer) begin
                        let_cnt <= let_cnt - LW'(1);
                        if (let_cnt == LW'(1)) state <= StDig;
                    end
                end
                StDig: begin
                    if (xfer) begin
                        dig_cnt <= dig_cnt - LW'(1);
                        if (dig_cnt == LW'(1)) state <= StSep;
                    end
                end
                StSep: begin
                    if (xfer) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign valid = (state != StIdle);
    assign busy  = (state != StIdle);

    always_comb begin
        char = 8'd0;
        unique case (state)
            StIdle: char = 8'd0;
            StLet:  char = (upper_q ? CH_A_UP : CH_A_LO) + {3'b000, li};
            StDig:  char = CH_0 + {4'b0000, di};
            StSep:  char = SEP_CHAR;
            default: char = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: byte streams, backpressure, rejection, mid-token reset.
module tb_id_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] let_len;
    logic [3:0] dig_len;
    logic [4:0] let_seed;
    logic       upper;
    logic [7:0] char;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    id_gen dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .let_len  (let_len),
        .dig_len  (dig_len),
        .let_seed (let_seed),
        .upper    (upper),
        .char     (char),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: request a token, return at the negedge after acceptance.
    task automatic request(input logic [3:0] n, input logic [3:0] m, input logic [4:0] seed,
                           input logic up);
        start    = 1'b1;
        let_len  = n;
        dig_len  = m;
        let_seed = seed;
        upper    = up;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Consume exp_q with a repeating ready pattern; optionally poke start while busy.
    task automatic collect(input string tag, input logic [31:0] rpat, input int plen,
                           input int exp_busy, input bit poke);
        int idx = 0;
        int cyc = 0;
        int busy_cyc = 0;
        logic stalled = 1'b0;
        logic [7:0] held = 8'd0;
        while (idx < exp_q.size() && cyc < 200) begin
            ready = rpat[cyc % plen];
            if (poke && cyc == 1) begin
                start    = 1'b1;
                let_len  = 4'd5;
                let_seed = 5'd10;
                upper    = ~upper;
            end
            if (poke && cyc == 2) start = 1'b0;
            if (busy) busy_cyc++;
            if (!valid) begin
                check($sformatf("%s valid@%0d", tag, idx), valid, 1);
                break;
            end
            if (stalled) check($sformatf("%s hold@%0d", tag, idx), char, held);
            if (ready) begin
                check($sformatf("%s ch%0d", tag, idx), char, exp_q[idx]);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = char;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check({tag, " timeout"}, idx, exp_q.size());
        ready = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " valid_after"}, valid, 0);
        if (exp_busy >= 0) check({tag, " busy_cycles"}, busy_cyc, exp_busy);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        let_len  = 4'd0;
        dig_len  = 4'd0;
        let_seed = 5'd0;
        upper    = 1'b0;
        ready    = 1'b0;

        @(negedge clk);
        check("rst char", char, 0);
        check("rst valid", valid, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic token "ab012 "
        exp_q = '{8'd97, 8'd98, 8'd48, 8'd49, 8'd50, 8'd32};
        request(4'd2, 4'd3, 5'd0, 1'b0);
        collect("basic", 32'h1, 1, 6, 1'b0);

        // Letter wrap, uppercase, start poked while busy must be ignored
        exp_q = '{8'd89, 8'd90, 8'd65, 8'd48, 8'd32};
        request(4'd3, 4'd1, 5'd24, 1'b1);
        collect("upwrap", 32'h1, 1, 5, 1'b1);
        check("upwrap idle", busy, 0);

        // Digit wrap
        exp_q = '{8'd122, 8'd48, 8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55,
                  8'd56, 8'd57, 8'd48, 8'd49, 8'd32};
        request(4'd1, 4'd12, 5'd25, 1'b0);
        collect("digwrap", 32'h1, 1, 14, 1'b0);

        // Backpressure: ready 1,0,0,1,0,1 repeating
        exp_q = '{8'd97, 8'd98, 8'd48, 8'd49, 8'd32};
        request(4'd2, 4'd2, 5'd0, 1'b0);
        collect("bp", 32'b101001, 6, -1, 1'b0);

        // Rejected request
        request(4'd0, 4'd5, 5'd0, 1'b0);
        check("rej err", err, 1);
        check("rej valid", valid, 0);
        @(negedge clk);
        check("rej err_pulse", err, 0);
        check("rej busy", busy, 0);

        // Reset after the 2nd digit of an N=2, M=4 token
        request(4'd2, 4'd4, 5'd0, 1'b0);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        check("mid char", char, 50);
        #1 reset = 1'b1;
        #1;
        check("mid valid", valid, 0);
        check("mid busy", busy, 0);
        check("mid char0", char, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("mid no_done", done, 0);
        end
        ready = 1'b0;
        exp_q = '{8'd97, 8'd48, 8'd32};
        request(4'd1, 4'd1, 5'd0, 1'b0);
        collect("fresh", 32'h1, 1, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/id_gen.md
Name: id_gen

Overview:
- Identifier token transmitter; the generating end of the letters-then-digits identifier recognizer.
- Takes a token request of N letters and M digits.
- Emits the token one ASCII byte per accepted transfer on a valid/ready byte stream, followed by one space separator.
- Drives the recognizer's char input in closed-loop benches.
- Also serves as a test-stream source in the character-processing pipeline.

Parameters:
- MAX_LEN, 15, maximum letter count and maximum digit count; sets count width LW = 4.
- SEP_CHAR, 8'd32, separator byte emitted after the last digit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  token request; sampled only in IDLE.
- let_len  input  4  letter count N, 1..15.
- dig_len  input  4  digit count M, 1..15.
- let_seed  input  5  index of the first letter, 0..25 (0 = 'a'/'A').
- upper  input  1  1 = letters 'A'..'Z', 0 = 'a'..'z'.
- char  output  8  ASCII byte being offered.
- valid  output  1  char is valid.
- ready  input  1  downstream accepts char this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse in the cycle after the separator transfer.
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - state = IDLE.
  - char = 8'd0, valid = 0, busy = 0, done = 0, err = 0.
  - All counters cleared; any in-flight token is abandoned with no done pulse.
- Handshake:
  - A transfer occurs on a rising edge where valid = 1 and ready = 1.
  - While valid = 1 and ready = 0, char and valid hold stable; valid never drops without a transfer.
  - valid never depends combinationally on ready.
- States: IDLE, LET, DIG, SEP.
- IDLE:
  - Request accepted when start = 1 and let_len != 0 and dig_len != 0.
  - On acceptance, latch N, M, upper, and letter index li = (let_seed > 25 ? 0 : let_seed); set digit index di = 0; go to LET.
  - First char is valid one cycle after start (latency 1).
  - If start = 1 and either length is 0: err = 1 for one cycle, stay in IDLE.
- LET:
  - char = (upper ? 8'd65 : 8'd97) + li.
  - On each transfer: li = (li == 25) ? 0 : li + 1, letter count decrements.
  - The transfer of the N-th letter moves to DIG.
- DIG:
  - char = 8'd48 + di.
  - On each transfer: di = (di == 9) ? 0 : di + 1.
  - The transfer of the M-th digit moves to SEP.
- SEP:
  - char = SEP_CHAR.
  - On transfer: go to IDLE and pulse done in the following cycle.
  - valid = 0 in IDLE.
- Back-to-back tokens: a start asserted in the done cycle (IDLE) is accepted; the inter-token gap is 1 idle cycle minimum.
- Request inputs (start, lengths, seed, upper) are ignored while busy = 1; the latched request governs the whole token.
- Total transfers per token = N + M + 1.
- Stream property: the recognizer's out is high exactly while it has consumed the digit bytes of the token.
- Reset mid-token: valid drops immediately (asynchronous); the next start begins a fresh token.

Decomposition:
- Shared package id_pkg, used by id_gen and the recognizer:
  - ASCII constants: CH_A_UP = 65, CH_A_LO = 97, CH_0 = 48, CH_SP = 32.
  - LETTER_CNT = 26, DIGIT_CNT = 10.
  - 2-bit state encoding localparams for IDLE/LET/DIG/SEP.
- One sub-module: id_wrap_cnt.
  - Modulo-K index counter with enable, synchronous load, and async reset.
  - Instantiated twice: K = 26 for letters, K = 10 for digits.
- The down-counters for N and M live in id_gen.

Test Plan:
- Basic token: reset, start with N=2, M=3, seed=0, upper=0, ready=1 → stream "a","b","0","1","2"," " (97,98,48,49,50,32) on consecutive cycles starting 1 cycle after start; done pulses once; busy is high for 6 cycles.
- Letter wrap and uppercase: N=3, M=1, seed=24, upper=1 → "Y","Z","A","0"," " (89,90,65,48,32).
- Digit wrap: N=1, M=12, seed=25, upper=0 → "z", "0".."9", "0", "1", " "; 14 transfers total; feeding the recognizer yields out=1 on the 12 cycles after each digit is consumed and 0 after the space.
- Backpressure: N=2, M=2, ready toggling 1,0,0,1,0,1,... → each char held stable while ready=0; no byte duplicated or skipped; the sequence still equals "ab01 ".
- Rejection and ignore: start with N=0, M=5 → err pulses 1 cycle, valid stays 0; start pulsed during a busy token → no effect on the stream.
- Reset mid-token: assert reset after the 2nd digit of an N=2, M=4 token → valid=0 and busy=0 immediately with no done pulse; a new token N=1, M=1 → "a","0"," ".
